ddr3_app_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the MIG 7-series user (app_*) interface, clocked by ui_clk.
- Sits between the MIG instance and two client ports: a write client (DAQ data sink) and a read client (readout).
- Gates all traffic on init_calib_complete and grants the two clients round-robin.
- Runs the app_en/app_rdy and app_wdf_wren/app_wdf_rdy handshakes, tracks outstanding reads, and returns read data in order.

---
 rtl/ddr3_app_arbiter_if.sv | 43 ++++
 rtl/ddr3_app_arbiter.sv | 136 +++++++++++++
 tb/tb_ddr3_app_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_app_arbiter_if.sv
// Bundle of MIG app_* signals and the two client ports served by ddr3_app_arbiter.
// The arbiter uses the master view; the MIG model / clients use the slave view.
interface ddr3_app_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 512
);
  logic              init_calib_complete;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [DATA_W-1:0] app_wdf_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic [6:0]        rd_outstanding;
  logic              busy;

  modport master (
    input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
           wr_ack, rd_ack, rd_data, rd_data_valid, rd_outstanding, busy
  );

  modport slave (
    output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
           wr_ack, rd_ack, rd_data, rd_data_valid, rd_outstanding, busy
  );
endinterface

// File: rtl/ddr3_app_arbiter.sv
// Round-robin write/read client arbiter for the MIG 7-series app interface.
// Runs the command and write-data handshakes and tracks in-flight reads.
module ddr3_app_arbiter #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 512,
  parameter int MAX_RD_OUT = 16
) (
  input  logic                clk,
  input  logic                sys_rst,
  ddr3_app_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t              state_q, state_d;
  logic                rd_first_q, rd_first_d;
  logic                app_en_q, app_en_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wren_q, wren_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_ack_q, wr_ack_d;
  logic                rd_ack_q, rd_ack_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvld_q;
  logic [6:0]          rd_out_q, rd_out_d;
  logic                wr_elig, rd_elig, rd_inc;

  always_comb begin
    state_d    = state_q;
    rd_first_d = rd_first_q;
    app_en_d   = app_en_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wren_d     = wren_q;
    wdata_d    = wdata_q;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    rd_inc     = 1'b0;
    rd_out_d   = rd_out_q;
    wr_elig    = bus.wr_req;
    rd_elig    = bus.rd_req && (rd_out_q < 7'(MAX_RD_OUT));

    case (state_q)
      IDLE: begin
        if (bus.init_calib_complete) begin
          if (wr_elig && (!rd_elig || !rd_first_q)) begin
            state_d    = WR;
            rd_first_d = 1'b1;
            app_en_d   = 1'b1;
            cmd_d      = 3'b000;
            addr_d     = bus.wr_addr;
            wren_d     = 1'b1;
            wdata_d    = bus.wr_data;
            wr_ack_d   = 1'b1;
          end else if (rd_elig) begin
            state_d    = RD;
            rd_first_d = 1'b0;
            app_en_d   = 1'b1;
            cmd_d      = 3'b001;
            addr_d     = bus.rd_addr;
            rd_ack_d   = 1'b1;
          end
        end
      end
      // Command and data handshakes retire independently; leave once both are done.
      WR: begin
        if (app_en_q && bus.app_rdy)   app_en_d = 1'b0;
        if (wren_q && bus.app_wdf_rdy) wren_d   = 1'b0;
        if (!app_en_d && !wren_d)      state_d  = IDLE;
      end
      RD: begin
        if (bus.app_rdy) begin
          app_en_d = 1'b0;
          rd_inc   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    case ({rd_inc, bus.app_rd_data_valid})
      2'b10:   rd_out_d = rd_out_q + 7'd1;
      2'b01:   rd_out_d = (rd_out_q == 7'd0) ? 7'd0 : rd_out_q - 7'd1;
      default: rd_out_d = rd_out_q;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= IDLE;
      rd_first_q <= 1'b0;
      app_en_q   <= 1'b0;
      cmd_q      <= 3'b000;
      addr_q     <= '0;
      wren_q     <= 1'b0;
      wdata_q    <= '0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      rdata_q    <= '0;
      rvld_q     <= 1'b0;
      rd_out_q   <= 7'd0;
    end else begin
      state_q    <= state_d;
      rd_first_q <= rd_first_d;
      app_en_q   <= app_en_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wren_q     <= wren_d;
      wdata_q    <= wdata_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      rdata_q    <= bus.app_rd_data;
      rvld_q     <= bus.app_rd_data_valid;
      rd_out_q   <= rd_out_d;
    end
  end

  assign bus.app_en         = app_en_q;
  assign bus.app_cmd        = cmd_q;
  assign bus.app_addr       = addr_q;
  assign bus.app_wdf_wren   = wren_q;
  assign bus.app_wdf_end    = wren_q;
  assign bus.app_wdf_data   = wdata_q;
  assign bus.wr_ack         = wr_ack_q;
  assign bus.rd_ack         = rd_ack_q;
  assign bus.rd_data        = rdata_q;
  assign bus.rd_data_valid  = rvld_q;
  assign bus.rd_outstanding = rd_out_q;
  assign bus.busy           = (state_q != IDLE);

  // Read data arriving with nothing in flight means the MIG and this counter disagree.
  rd_underflow_a: assert property (@(posedge clk) disable iff (!sys_rst)
    !(bus.app_rd_data_valid && !rd_inc && (rd_out_q == 7'd0)));

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Bench for ddr3_app_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_ddr3_app_arbiter;
  localparam int AW   = 28;
  localparam int DW   = 64;
  localparam int MAXR = 16;

  logic clk;
  logic sys_rst;

  ddr3_app_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ddr3_app_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_RD_OUT(MAXR)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: one transaction at a time, pending handshakes, in-flight reads.
  bit          m_busy, m_cmd_pend, m_dat_pend, m_is_rd, m_rd_turn;
  logic [2:0]  m_cmd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int          m_out;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_cmd_pend = 0; m_dat_pend = 0; m_is_rd = 0; m_rd_turn = 0;
    m_cmd = 3'b000; m_addr = '0; m_data = '0; m_out = 0;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_val({pfx, "_app_en"},   64'(bus.app_en), 64'd0);
    check_val({pfx, "_app_cmd"},  64'(bus.app_cmd), 64'd0);
    check_val({pfx, "_app_addr"}, 64'(bus.app_addr), 64'd0);
    check_val({pfx, "_wren"},     64'(bus.app_wdf_wren), 64'd0);
    check_val({pfx, "_wdf_end"},  64'(bus.app_wdf_end), 64'd0);
    check_val({pfx, "_wdf_data"}, 64'(bus.app_wdf_data), 64'd0);
    check_val({pfx, "_wr_ack"},   64'(bus.wr_ack), 64'd0);
    check_val({pfx, "_rd_ack"},   64'(bus.rd_ack), 64'd0);
    check_val({pfx, "_rd_data"},  64'(bus.rd_data), 64'd0);
    check_val({pfx, "_rd_vld"},   64'(bus.rd_data_valid), 64'd0);
    check_val({pfx, "_rd_out"},   64'(bus.rd_outstanding), 64'd0);
    check_val({pfx, "_busy"},     64'(bus.busy), 64'd0);
  endtask

  // Advance one clock; inputs seen at the edge are those still driven at the next negedge.
  task automatic step();
    bit cmd_acc, dat_acc, gw, gr, we, re;
    @(posedge clk);
    @(negedge clk);
    cmd_acc = m_cmd_pend && bus.app_rdy;
    dat_acc = m_dat_pend && bus.app_wdf_rdy;
    gw = 0; gr = 0;
    if (m_busy) begin
      if (cmd_acc) m_cmd_pend = 0;
      if (dat_acc) m_dat_pend = 0;
      if (!m_cmd_pend && !m_dat_pend) m_busy = 0;
    end else if (bus.init_calib_complete) begin
      we = bus.wr_req;
      re = bus.rd_req && (m_out < MAXR);
      if (we && re) begin
        if (m_rd_turn) gr = 1; else gw = 1;
      end else begin
        gw = we; gr = re;
      end
      if (gw) begin
        m_busy = 1; m_cmd_pend = 1; m_dat_pend = 1; m_is_rd = 0;
        m_cmd = 3'b000; m_addr = bus.wr_addr; m_data = bus.wr_data; m_rd_turn = 1;
      end
      if (gr) begin
        m_busy = 1; m_cmd_pend = 1; m_dat_pend = 0; m_is_rd = 1;
        m_cmd = 3'b001; m_addr = bus.rd_addr; m_rd_turn = 0;
      end
    end
    m_out = m_out + ((cmd_acc && m_is_rd) ? 1 : 0) - (bus.app_rd_data_valid ? 1 : 0);
    if (m_out < 0) m_out = 0;

    check_val("wr_ack",   64'(bus.wr_ack), 64'(gw));
    check_val("rd_ack",   64'(bus.rd_ack), 64'(gr));
    check_val("busy",     64'(bus.busy), 64'(m_busy));
    check_val("app_en",   64'(bus.app_en), 64'(m_cmd_pend));
    check_val("wren",     64'(bus.app_wdf_wren), 64'(m_dat_pend));
    check_val("wdf_end",  64'(bus.app_wdf_end), 64'(m_dat_pend));
    check_val("app_cmd",  64'(bus.app_cmd), 64'(m_cmd));
    check_val("app_addr", 64'(bus.app_addr), 64'(m_addr));
    check_val("wdf_data", 64'(bus.app_wdf_data), 64'(m_data));
    check_val("rd_out",   64'(bus.rd_outstanding), 64'(m_out));
    check_val("rd_vld",   64'(bus.rd_data_valid), 64'(bus.app_rd_data_valid));
    check_val("rd_data",  64'(bus.rd_data), 64'(bus.app_rd_data));
  endtask

  task automatic drain();
    bus.wr_req = 0; bus.rd_req = 0; bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      bus.app_rd_data_valid = (m_out > 0);
      bus.app_rd_data = {$urandom, $urandom};
      step();
    end
    bus.app_rd_data_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_ack, n_en, n_wren, n_rdack;
    sys_rst = 0;
    bus.init_calib_complete = 0; bus.app_rdy = 0; bus.app_wdf_rdy = 0;
    bus.app_rd_data = '0; bus.app_rd_data_valid = 0;
    bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 0; bus.rd_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    sys_rst = 1;

    // Calibration gating
    bus.wr_req = 1; bus.wr_addr = 28'h0ABCDE0; bus.wr_data = 64'h508050FF;
    n_ack = 0; n_en = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      n_ack += int'(bus.wr_ack);
      n_en  += int'(bus.app_en);
    end
    check_val("calib_gate_acks", 64'(n_ack), 64'd0);
    check_val("calib_gate_en",   64'(n_en), 64'd0);
    bus.init_calib_complete = 1;
    step();
    check_val("calib_rise_ack",  64'(bus.wr_ack), 64'd1);
    check_val("calib_rise_en",   64'(bus.app_en), 64'd1);
    check_val("calib_rise_cmd",  64'(bus.app_cmd), 64'd0);
    check_val("calib_rise_addr", 64'(bus.app_addr), 64'h0ABCDE0);
    n_wren = int'(bus.app_wdf_wren);

    // Split write handshake: command first, data three cycles later
    bus.wr_req = 0; bus.wr_data = '0; bus.app_rdy = 1; bus.app_wdf_rdy = 0;
    step();
    check_val("split_en_drop", 64'(bus.app_en), 64'd0);
    n_wren += int'(bus.app_wdf_wren);
    for (int i = 0; i < 2; i++) begin
      step();
      n_wren += int'(bus.app_wdf_wren);
    end
    check_val("split_data_stable", 64'(bus.app_wdf_data), 64'h508050FF);
    check_val("split_busy_hold",   64'(bus.busy), 64'd1);
    bus.app_wdf_rdy = 1;
    step();
    n_wren += int'(bus.app_wdf_wren);
    check_val("split_wren_cycles", 64'(n_wren), 64'd4);
    check_val("split_busy_fall",   64'(bus.busy), 64'd0);

    // Asynchronous reset while stuck in WR
    bus.wr_req = 1; bus.wr_addr = AW'($urandom); bus.wr_data = {$urandom, $urandom};
    bus.app_rdy = 0; bus.app_wdf_rdy = 0;
    step();
    bus.wr_req = 0;
    step();
    check_val("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2 sys_rst = 0;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1;
    model_reset();

    // Round-robin with both clients requesting and MIG always ready
    bus.wr_req = 1; bus.rd_req = 1; bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    bus.wr_addr = 28'h0000100; bus.rd_addr = 28'h0000200;
    for (int i = 0; i < 8; i++) begin
      step();
      check_val("rr_wr_ack", 64'(bus.wr_ack), 64'((i % 4) == 0));
      check_val("rr_rd_ack", 64'(bus.rd_ack), 64'((i % 4) == 2));
    end
    drain();

    // Outstanding-read limit with no data coming back
    bus.rd_req = 1; bus.app_rdy = 1;
    n_rdack = 0;
    for (int i = 0; i < 60; i++) begin
      bus.rd_addr = AW'($urandom);
      step();
      n_rdack += int'(bus.rd_ack);
    end
    check_val("limit_rd_acks", 64'(n_rdack), 64'(MAXR));
    check_val("limit_rd_out",  64'(bus.rd_outstanding), 64'(MAXR));
    bus.app_rd_data_valid = 1; bus.app_rd_data = 64'h1111_2222_3333_4444;
    step();
    check_val("limit_dec", 64'(bus.rd_outstanding), 64'(MAXR - 1));
    bus.app_rd_data_valid = 0; bus.app_rdy = 0;
    step();
    check_val("limit_regrant", 64'(bus.rd_ack), 64'd1);

    // Read acceptance coinciding with returned data
    bus.rd_req = 0; bus.app_rdy = 1;
    bus.app_rd_data_valid = 1; bus.app_rd_data = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    check_val("simul_rd_out",  64'(bus.rd_outstanding), 64'(MAXR - 1));
    check_val("simul_rd_vld",  64'(bus.rd_data_valid), 64'd1);
    check_val("simul_rd_data", 64'(bus.rd_data), 64'hDEAD_BEEF_CAFE_F00D);
    bus.app_rd_data_valid = 0;
    step();
    check_val("simul_vld_drop", 64'(bus.rd_data_valid), 64'd0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) bus.init_calib_complete = ~bus.init_calib_complete;
      bus.wr_req            = ($urandom_range(0, 9) < 4);
      bus.rd_req            = ($urandom_range(0, 9) < 4);
      bus.wr_addr           = AW'($urandom);
      bus.rd_addr           = AW'($urandom);
      bus.wr_data           = {$urandom, $urandom};
      bus.app_rdy           = ($urandom_range(0, 3) != 0);
      bus.app_wdf_rdy       = ($urandom_range(0, 3) != 0);
      bus.app_rd_data_valid = (m_out > 0) && ($urandom_range(0, 2) == 0);
      bus.app_rd_data       = {$urandom, $urandom};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
